// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the 8-to-16-bit async FIFO.
// It waits for a full burst in the FIFO, then streams it out as sop/eop-framed valid/ready words.
`timescale 1ns/1ps
module fifo_burst_reader #(
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 8,
    parameter int BURST_LEN = 32,
    parameter int OUT_DEPTH = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic              rd_clk,
    input  logic              rst,
    input  logic              rd_rst_busy,
    input  logic [CNT_W-1:0]  rd_data_count,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_valid,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sop,
    output logic              m_eop,
    output logic [15:0]       bursts_done,
    output logic              proto_err
);

    localparam int BW = $clog2(BURST_LEN);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BW-1:0]    LAST_IDX = BW'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(BURST_LEN);
    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [AW+1:0]    DEPTH_C  = (AW+2)'(OUT_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BW-1:0]     issue_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              rd_en_q;
    logic [DATA_W-1:0] q_mem [OUT_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       q_occ;
    logic [BW-1:0]     out_cnt;
    logic              push;
    logic              pop;
    logic              credit_ok;

    // A read is only issued if its word is guaranteed a queue slot on arrival.
    assign credit_ok = ((AW+2)'(q_occ) + (AW+2)'(rd_en_q)) < DEPTH_C;

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (rd_data_count >= THRESH && !rd_rst_busy)
                    state_nxt = BURST;
            end
            BURST: begin
                fifo_rd_en = !rd_rst_busy && !fifo_empty && credit_ok;
                if (fifo_rd_en && issue_cnt == LAST_IDX)
                    state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            gap_cnt   <= '0;
            rd_en_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_en_q <= fifo_rd_en;
            if (fifo_rd_en)
                issue_cnt <= (issue_cnt == LAST_IDX) ? '0 : issue_cnt + 1'b1;
            if (state == GAP)
                gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
            else
                gap_cnt <= '0;
        end
    end

    // Only words answering our own reads enter the queue; stray valids are flagged instead.
    assign push    = fifo_valid && rd_en_q;
    assign m_valid = (q_occ != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? q_mem[rd_ptr] : '0;
    assign m_sop   = m_valid && (out_cnt == '0);
    assign m_eop   = m_valid && (out_cnt == LAST_IDX);

    always_ff @(posedge rd_clk) begin
        if (push)
            q_mem[wr_ptr] <= fifo_dout;
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_occ  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_occ <= q_occ + 1'b1;
                2'b01:   q_occ <= q_occ - 1'b1;
                default: q_occ <= q_occ;
            endcase
        end
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            out_cnt     <= '0;
            bursts_done <= '0;
            proto_err   <= 1'b0;
        end else begin
            if (pop)
                out_cnt <= (out_cnt == LAST_IDX) ? '0 : out_cnt + 1'b1;
            if (pop && m_eop)
                bursts_done <= bursts_done + 16'd1;
            // Valid with no read outstanding, or a read that never produced data.
            if (fifo_valid != rd_en_q)
                proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO and a stream sink.
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    logic        rd_clk = 1'b0;
    logic        rst;
    logic        rd_rst_busy;
    logic [7:0]  rd_data_count;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_valid;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sop;
    logic        m_eop;
    logic [15:0] bursts_done;
    logic        proto_err;

    int checks = 0;
    int passed = 0;

    int cyc = 0;
    int fifo_level;
    int tb_occ;
    int max_credit;
    int rd_en_cnt;
    int first_rd_cyc;
    int first_valid_cyc;
    int cur_run;
    int max_run;
    int last_rd_cyc;
    int stream_err;
    logic [15:0] fifo_next;
    bit          rd_en_prev;
    bit          hold_pending;
    bit          ready_mode;
    bit          drop_valid;
    logic [15:0] hold_data;
    logic        hold_sop;
    logic        hold_eop;
    logic [15:0] pop_data[$];
    logic        pop_sop[$];
    logic        pop_eop[$];
    int          gaps[$];
    logic [15:0] ready_vec = 16'b1001_0001_1000_1001;

    fifo_burst_reader dut (
        .rd_clk        (rd_clk),
        .rst           (rst),
        .rd_rst_busy   (rd_rst_busy),
        .rd_data_count (rd_data_count),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_valid    (fifo_valid),
        .fifo_rd_en    (fifo_rd_en),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_sop         (m_sop),
        .m_eop         (m_eop),
        .bursts_done   (bursts_done),
        .proto_err     (proto_err)
    );

    always #5 rd_clk = ~rd_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_level();
        rd_data_count = (fifo_level > 255) ? 8'hFF : 8'(fifo_level);
        fifo_empty    = (fifo_level == 0);
    endtask

    task automatic set_level(input int n);
        fifo_level = n;
        drive_level();
    endtask

    task automatic clear_stats();
        max_credit      = 0;
        rd_en_cnt       = 0;
        first_rd_cyc    = -1;
        first_valid_cyc = -1;
        cur_run         = 0;
        max_run         = 0;
        last_rd_cyc     = -1;
        stream_err      = 0;
        pop_data.delete();
        pop_sop.delete();
        pop_eop.delete();
        gaps.delete();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        rd_rst_busy  = 1'b0;
        fifo_valid   = 1'b0;
        fifo_dout    = 16'h0000;
        m_ready      = 1'b1;
        ready_mode   = 1'b0;
        drop_valid   = 1'b0;
        rd_en_prev   = 1'b0;
        hold_pending = 1'b0;
        tb_occ       = 0;
        set_level(0);
        repeat (3) @(posedge rd_clk);
        #1;
        rst = 1'b0;
        clear_stats();
    endtask

    // One clock: sample at the falling edge, then play the FIFO and sink just after the rising edge.
    task automatic tick();
        logic rd;
        logic popped;
        int   credit;
        @(negedge rd_clk);
        cyc++;
        rd     = fifo_rd_en;
        popped = m_valid && m_ready;
        if (m_valid !== (tb_occ > 0))
            stream_err++;
        if (hold_pending && (m_valid !== 1'b1 || m_data !== hold_data ||
                             m_sop !== hold_sop || m_eop !== hold_eop))
            stream_err++;
        hold_pending = m_valid && !m_ready;
        hold_data    = m_data;
        hold_sop     = m_sop;
        hold_eop     = m_eop;
        credit = tb_occ + (rd_en_prev ? 1 : 0);
        if (credit > max_credit)
            max_credit = credit;
        if (rd) begin
            rd_en_cnt++;
            if (first_rd_cyc < 0)
                first_rd_cyc = cyc;
            if (last_rd_cyc >= 0 && cyc - last_rd_cyc > 1)
                gaps.push_back(cyc - last_rd_cyc - 1);
            last_rd_cyc = cyc;
            cur_run++;
            if (cur_run > max_run)
                max_run = cur_run;
        end else begin
            cur_run = 0;
        end
        if (m_valid && first_valid_cyc < 0)
            first_valid_cyc = cyc;
        if (popped) begin
            pop_data.push_back(m_data);
            pop_sop.push_back(m_sop);
            pop_eop.push_back(m_eop);
        end
        tb_occ = tb_occ + (rd_en_prev ? 1 : 0) - (popped ? 1 : 0);
        if (rd && fifo_level > 0)
            fifo_level--;
        @(posedge rd_clk);
        #1;
        fifo_valid = rd;
        if (rd) begin
            fifo_dout = fifo_next;
            fifo_next = fifo_next + 16'd1;
            if (drop_valid) begin
                fifo_valid = 1'b0;
                drop_valid = 1'b0;
            end
        end
        rd_en_prev = rd;
        drive_level();
        if (ready_mode)
            m_ready = ready_vec[cyc % 16];
    endtask

    task automatic test_reset();
        int start;
        rst          = 1'b1;
        rd_rst_busy  = 1'b1;
        m_ready      = 1'b1;
        ready_mode   = 1'b0;
        drop_valid   = 1'b0;
        fifo_valid   = 1'b0;
        fifo_dout    = 16'h0000;
        fifo_next    = 16'h0000;
        rd_en_prev   = 1'b0;
        hold_pending = 1'b0;
        tb_occ       = 0;
        set_level(40);
        repeat (3) @(posedge rd_clk);
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, m_sop, m_eop, proto_err} !== 5'b0)
            $display("[TB] FAIL reset_flags: got %b expected 00000", {fifo_rd_en, m_valid, m_sop, m_eop, proto_err});
        else passed++;
        checks++;
        if (m_data !== 16'h0000)
            $display("[TB] FAIL reset_data: got %h expected 0000", m_data);
        else passed++;
        checks++;
        if (bursts_done !== 16'd0)
            $display("[TB] FAIL reset_bursts: got %0d expected 0", bursts_done);
        else passed++;

        rst = 1'b0;
        clear_stats();
        repeat (20) tick();
        checks++;
        if (rd_en_cnt !== 0)
            $display("[TB] FAIL busy_blocks_rd: got %0d reads expected 0", rd_en_cnt);
        else passed++;

        rd_rst_busy = 1'b0;
        start = cyc;
        for (int i = 0; i < 10 && first_rd_cyc < 0; i++) tick();
        checks++;
        if (first_rd_cyc - start !== 2)
            $display("[TB] FAIL busy_release_latency: got %0d expected 2", first_rd_cyc - start);
        else passed++;

        for (int i = 0; i < 200 && pop_data.size() < 32; i++) tick();
        checks++;
        if (bursts_done !== 16'd1 || pop_data.size() !== 32)
            $display("[TB] FAIL reset_first_burst: got bursts %0d pops %0d expected 1 and 32", bursts_done, pop_data.size());
        else passed++;
    endtask

    task automatic test_single_burst();
        int err;
        do_reset();
        fifo_next = 16'h0100;
        set_level(31);
        repeat (100) tick();
        checks++;
        if (rd_en_cnt !== 0 || first_valid_cyc !== -1)
            $display("[TB] FAIL below_threshold: got %0d reads valid_cyc %0d expected 0 and -1", rd_en_cnt, first_valid_cyc);
        else passed++;

        clear_stats();
        set_level(32);
        for (int i = 0; i < 200 && pop_data.size() < 32; i++) tick();
        repeat (10) tick();
        checks++;
        if (rd_en_cnt !== 32 || max_run !== 32)
            $display("[TB] FAIL burst_reads: got %0d reads longest run %0d expected 32 and 32", rd_en_cnt, max_run);
        else passed++;
        checks++;
        if (first_valid_cyc - first_rd_cyc !== 2)
            $display("[TB] FAIL read_latency: got %0d expected 2", first_valid_cyc - first_rd_cyc);
        else passed++;
        checks++;
        if (pop_data.size() !== 32)
            $display("[TB] FAIL burst_pop_count: got %0d expected 32", pop_data.size());
        else passed++;
        err = 0;
        for (int i = 0; i < pop_data.size(); i++) begin
            if (pop_data[i] !== 16'h0100 + 16'(i)) err++;
            if (pop_sop[i] !== (i == 0)) err++;
            if (pop_eop[i] !== (i == 31)) err++;
        end
        checks++;
        if (err !== 0)
            $display("[TB] FAIL burst_order_framing: got %0d bad fields expected 0", err);
        else passed++;
        checks++;
        if (pop_data.size() == 32 && (pop_data[0] !== 16'h0100 || pop_data[31] !== 16'h011F))
            $display("[TB] FAIL burst_ends: got %h..%h expected 0100..011F", pop_data[0], pop_data[31]);
        else if (pop_data.size() != 32)
            $display("[TB] FAIL burst_ends: got %0d words expected 32", pop_data.size());
        else passed++;
        checks++;
        if (bursts_done !== 16'd1 || stream_err !== 0)
            $display("[TB] FAIL burst_done_count: got bursts %0d stream errors %0d expected 1 and 0", bursts_done, stream_err);
        else passed++;
    endtask

    task automatic test_backpressure();
        int err;
        do_reset();
        fifo_next  = 16'h0200;
        ready_mode = 1'b1;
        set_level(32);
        for (int i = 0; i < 600 && pop_data.size() < 32; i++) tick();
        repeat (20) tick();
        checks++;
        if (pop_data.size() !== 32)
            $display("[TB] FAIL bp_pop_count: got %0d expected 32", pop_data.size());
        else passed++;
        err = 0;
        for (int i = 0; i < pop_data.size(); i++) begin
            if (pop_data[i] !== 16'h0200 + 16'(i)) err++;
            if (pop_sop[i] !== (i == 0)) err++;
            if (pop_eop[i] !== (i == 31)) err++;
        end
        checks++;
        if (err !== 0)
            $display("[TB] FAIL bp_order: got %0d bad fields expected 0", err);
        else passed++;
        checks++;
        if (max_credit > 4)
            $display("[TB] FAIL bp_credit: got %0d expected at most 4", max_credit);
        else passed++;
        checks++;
        if (rd_en_cnt !== 32)
            $display("[TB] FAIL bp_reads: got %0d expected 32", rd_en_cnt);
        else passed++;
        checks++;
        if (stream_err !== 0 || bursts_done !== 16'd1)
            $display("[TB] FAIL bp_stream: got stream errors %0d bursts %0d expected 0 and 1", stream_err, bursts_done);
        else passed++;
        ready_mode = 1'b0;
        m_ready    = 1'b1;
    endtask

    task automatic test_back_to_back();
        int err;
        do_reset();
        fifo_next = 16'h0300;
        set_level(80);
        for (int i = 0; i < 400 && pop_data.size() < 64; i++) tick();
        repeat (40) tick();
        checks++;
        if (rd_en_cnt !== 64 || bursts_done !== 16'd2)
            $display("[TB] FAIL b2b_counts: got reads %0d bursts %0d expected 64 and 2", rd_en_cnt, bursts_done);
        else passed++;
        checks++;
        if (gaps.size() !== 1)
            $display("[TB] FAIL b2b_gap_count: got %0d idle gaps expected 1", gaps.size());
        else if (gaps[0] < 5)
            $display("[TB] FAIL b2b_gap_len: got %0d expected at least 5", gaps[0]);
        else passed++;
        err = 0;
        for (int i = 0; i < pop_data.size(); i++) begin
            if (pop_data[i] !== 16'h0300 + 16'(i)) err++;
            if (pop_sop[i] !== (i % 32 == 0)) err++;
            if (pop_eop[i] !== (i % 32 == 31)) err++;
        end
        checks++;
        if (err !== 0 || pop_data.size() !== 64)
            $display("[TB] FAIL b2b_framing: got %0d bad fields over %0d words expected 0 over 64", err, pop_data.size());
        else passed++;
    endtask

    task automatic test_mid_burst_reset();
        do_reset();
        fifo_next = 16'h0400;
        set_level(32);
        for (int i = 0; i < 100 && pop_data.size() < 9; i++) tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h0409)
            $display("[TB] FAIL abort_word10: got valid %b data %h expected 1 0409", m_valid, m_data);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, m_sop, m_eop} !== 4'b0 || m_data !== 16'h0000)
            $display("[TB] FAIL abort_async_clear: got flags %b data %h expected 0000 0000", {fifo_rd_en, m_valid, m_sop, m_eop}, m_data);
        else passed++;
        fifo_valid   = 1'b0;
        rd_en_prev   = 1'b0;
        hold_pending = 1'b0;
        tb_occ       = 0;
        repeat (2) @(posedge rd_clk);
        #1;
        rst = 1'b0;
        clear_stats();
        set_level(20);
        repeat (20) tick();
        checks++;
        if (rd_en_cnt !== 0 || bursts_done !== 16'd0)
            $display("[TB] FAIL abort_wait_threshold: got reads %0d bursts %0d expected 0 and 0", rd_en_cnt, bursts_done);
        else passed++;
        fifo_next = 16'h0500;
        set_level(32);
        for (int i = 0; i < 200 && pop_data.size() < 32; i++) tick();
        checks++;
        if (pop_data.size() !== 32)
            $display("[TB] FAIL abort_next_count: got %0d expected 32", pop_data.size());
        else if (pop_data[0] !== 16'h0500 || pop_sop[0] !== 1'b1 || pop_eop[31] !== 1'b1)
            $display("[TB] FAIL abort_next_framing: got %h sop %b eop %b expected 0500 1 1", pop_data[0], pop_sop[0], pop_eop[31]);
        else passed++;
        checks++;
        if (bursts_done !== 16'd1)
            $display("[TB] FAIL abort_next_bursts: got %0d expected 1", bursts_done);
        else passed++;
    endtask

    task automatic test_proto_err();
        do_reset();
        checks++;
        if (proto_err !== 1'b0)
            $display("[TB] FAIL err_clean: got %b expected 0", proto_err);
        else passed++;
        fifo_valid = 1'b1;
        fifo_dout  = 16'hDEAD;
        tick();
        checks++;
        if (proto_err !== 1'b1)
            $display("[TB] FAIL err_stray_valid: got %b expected 1", proto_err);
        else passed++;
        repeat (10) tick();
        checks++;
        if (proto_err !== 1'b1)
            $display("[TB] FAIL err_sticky: got %b expected 1", proto_err);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (proto_err !== 1'b0)
            $display("[TB] FAIL err_cleared_by_rst: got %b expected 0", proto_err);
        else passed++;
        repeat (2) @(posedge rd_clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_underflow();
        do_reset();
        fifo_next  = 16'h0600;
        drop_valid = 1'b1;
        set_level(32);
        for (int i = 0; i < 20 && rd_en_cnt < 3; i++) tick();
        checks++;
        if (proto_err !== 1'b1)
            $display("[TB] FAIL err_underflow: got %b expected 1", proto_err);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_backpressure();
        test_back_to_back();
        test_mid_burst_reset();
        test_proto_err();
        test_underflow();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
